// File: rtl/game_state_controller.sv
// Game flow controller: IDLE -> READY -> PLAY -> DYING -> READY/GAME_OVER.
// Tracks lives, the round-reset strobe, the freeze gate and the high score.
//
// Ports:
//   clk            system clock, rising edge
//   rst            asynchronous active-high reset
//   tick           one-cycle frame strobe
//   start_btn      start request level (synchronous)
//   pacman_is_dead death level from game logic (used only in PLAY)
//   score_bcd      current score, 4 BCD digits
//   state          IDLE=0 READY=1 PLAY=2 DYING=3 GAME_OVER=4
//   freeze         high in every state except PLAY
//   round_rst      one-cycle sprite reset pulse
//   lives          remaining lives
//   high_score_bcd best score since reset
//   game_over      high while in GAME_OVER
module game_state_controller #(
  parameter int START_LIVES      = 3,
  parameter int READY_TICKS      = 120,
  parameter int DEATH_HOLD_TICKS = 60
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick,
  input  logic        start_btn,
  input  logic        pacman_is_dead,
  input  logic [15:0] score_bcd,
  output logic [2:0]  state,
  output logic        freeze,
  output logic        round_rst,
  output logic [1:0]  lives,
  output logic [15:0] high_score_bcd,
  output logic        game_over
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READY = 3'd1,
    S_PLAY  = 3'd2,
    S_DYING = 3'd3,
    S_OVER  = 3'd4
  } state_t;

  localparam logic [7:0] LP_READY = 8'(READY_TICKS);
  localparam logic [7:0] LP_HOLD  = 8'(DEATH_HOLD_TICKS);
  localparam logic [1:0] LP_LIVES = 2'(START_LIVES);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [7:0]  r_cnt;
  logic [7:0]  w_cnt_nxt;
  logic [7:0]  w_cnt_inc;
  logic [1:0]  r_lives;
  logic [1:0]  w_lives_nxt;
  logic [15:0] r_hs;
  logic [15:0] w_hs_nxt;
  logic        r_start_prev;
  logic        w_start_ev;
  logic        r_round_rst;
  logic        w_round_rst_nxt;
  logic        r_freeze;
  logic        r_game_over;

  assign w_start_ev = start_btn & ~r_start_prev;

  // Counter saturates so a stray long run can never wrap
  assign w_cnt_inc = (r_cnt == 8'hFF) ? r_cnt : r_cnt + 8'd1;

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_lives_nxt     = r_lives;
    w_hs_nxt        = r_hs;
    w_round_rst_nxt = 1'b0;
    unique case (r_state)
      S_IDLE, S_OVER: begin
        if (w_start_ev) begin
          w_lives_nxt     = LP_LIVES;
          w_cnt_nxt       = 8'd0;
          w_round_rst_nxt = 1'b1;
          w_state_nxt     = S_READY;
        end
      end
      S_READY: begin
        if (tick) begin
          w_cnt_nxt = w_cnt_inc;
          if (w_cnt_inc == LP_READY) begin
            w_cnt_nxt   = 8'd0;
            w_state_nxt = S_PLAY;
          end
        end
      end
      S_PLAY: begin
        if (score_bcd > r_hs)
          w_hs_nxt = score_bcd;
        // Death wins over a same-cycle tick
        if (pacman_is_dead) begin
          w_state_nxt = S_DYING;
          w_cnt_nxt   = 8'd0;
          w_lives_nxt = (r_lives == 2'd0) ? 2'd0
                                          : r_lives - 2'd1;
        end
      end
      S_DYING: begin
        if (tick) begin
          w_cnt_nxt = w_cnt_inc;
          if (w_cnt_inc == LP_HOLD) begin
            w_cnt_nxt = 8'd0;
            if (r_lives == 2'd0) begin
              w_state_nxt = S_OVER;
            end else begin
              w_state_nxt     = S_READY;
              w_round_rst_nxt = 1'b1;
            end
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= 8'd0;
      r_lives      <= 2'd0;
      r_hs         <= 16'd0;
      r_start_prev <= 1'b1;
      r_round_rst  <= 1'b0;
      r_freeze     <= 1'b1;
      r_game_over  <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_lives      <= w_lives_nxt;
      r_hs         <= w_hs_nxt;
      r_start_prev <= start_btn;
      r_round_rst  <= w_round_rst_nxt;
      r_freeze     <= (w_state_nxt != S_PLAY);
      r_game_over  <= (w_state_nxt == S_OVER);
    end
  end

  assign state          = r_state;
  assign freeze         = r_freeze;
  assign round_rst      = r_round_rst;
  assign lives          = r_lives;
  assign high_score_bcd = r_hs;
  assign game_over      = r_game_over;

endmodule

// File: tb/tb_game_state_controller.sv
// Randomized + directed bench for game_state_controller.
// Compares all outputs every cycle against a behavioural game-flow model.
module tb_game_state_controller;

  localparam int SL = 3;
  localparam int RT = 2;
  localparam int DH = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        tick = 1'b0;
  logic        start_btn = 1'b0;
  logic        pacman_is_dead = 1'b0;
  logic [15:0] score_bcd = 16'd0;
  logic [2:0]  state;
  logic        freeze;
  logic        round_rst;
  logic [1:0]  lives;
  logic [15:0] high_score_bcd;
  logic        game_over;

  int n_tests = 0;
  int n_fail  = 0;

  // model: phase 0 idle,1 ready,2 play,3 dying,4 over
  int m_ph;
  int m_lives;
  int m_ticks;
  int m_hs;
  bit m_prev;
  bit m_rr;

  game_state_controller #(
    .START_LIVES(SL),
    .READY_TICKS(RT),
    .DEATH_HOLD_TICKS(DH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .tick(tick),
    .start_btn(start_btn),
    .pacman_is_dead(pacman_is_dead),
    .score_bcd(score_bcd),
    .state(state),
    .freeze(freeze),
    .round_rst(round_rst),
    .lives(lives),
    .high_score_bcd(high_score_bcd),
    .game_over(game_over)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_ph    = 0;
    m_lives = 0;
    m_ticks = 0;
    m_hs    = 0;
    m_prev  = 1'b1;
    m_rr    = 1'b0;
  endtask

  task automatic m_new_round();
    m_lives = SL;
    m_ticks = 0;
    m_rr    = 1'b1;
    m_ph    = 1;
  endtask

  task automatic m_step();
    bit ev;
    ev     = start_btn && !m_prev;
    m_prev = start_btn;
    m_rr   = 1'b0;
    if (m_ph == 0 || m_ph == 4) begin
      if (ev) m_new_round();
    end else if (m_ph == 1) begin
      if (tick) begin
        m_ticks = (m_ticks < 255) ? m_ticks + 1 : 255;
        if (m_ticks == RT) begin
          m_ph = 2;
          m_ticks = 0;
        end
      end
    end else if (m_ph == 2) begin
      if (int'(score_bcd) > m_hs) m_hs = int'(score_bcd);
      if (pacman_is_dead) begin
        m_ph    = 3;
        m_ticks = 0;
        m_lives = (m_lives > 0) ? m_lives - 1 : 0;
      end
    end else begin
      if (tick) begin
        m_ticks = (m_ticks < 255) ? m_ticks + 1 : 255;
        if (m_ticks == DH) begin
          m_ticks = 0;
          if (m_lives == 0) begin
            m_ph = 4;
          end else begin
            m_ph = 1;
            m_rr = 1'b1;
          end
        end
      end
    end
  endtask

  task automatic cmp_all(input string tag);
    chk({tag, ".state"}, 32'(state), 32'(m_ph));
    chk({tag, ".freeze"}, 32'(freeze), 32'(m_ph != 2));
    chk({tag, ".rrst"}, 32'(round_rst), 32'(m_rr));
    chk({tag, ".lives"}, 32'(lives), 32'(m_lives));
    chk({tag, ".hs"}, 32'(high_score_bcd), 32'(m_hs));
    chk({tag, ".gover"}, 32'(game_over), 32'(m_ph == 4));
  endtask

  task automatic cyc(input string tag, input bit s,
                     input bit t, input bit d,
                     input logic [15:0] sc);
    start_btn      = s;
    tick           = t;
    pacman_is_dead = d;
    score_bcd      = sc;
    @(posedge clk);
    if (rst) m_reset();
    else m_step();
    #1;
    cmp_all(tag);
  endtask

  task automatic ticks(input string tag, input int n,
                       input logic [15:0] sc);
    for (int i = 0; i < n; i++) begin
      cyc(tag, 0, 1, 0, sc);
      cyc(tag, 0, 0, 0, sc);
    end
  endtask

  initial begin
    m_reset();
    #1 rst = 1'b1;
    #1;
    cmp_all("rst_async");
    cyc("rst_hold", 0, 0, 0, 16'h0);
    rst = 1'b0;
    cyc("post_rst", 0, 0, 0, 16'h0);
    chk("no_rr_release", 32'(round_rst), 32'd0);

    // start game
    cyc("start", 1, 0, 0, 16'h0);
    chk("start_state", 32'(state), 32'd1);
    chk("start_lives", 32'(lives), 32'd3);
    chk("start_rr", 32'(round_rst), 32'd1);
    cyc("start2", 1, 0, 0, 16'h0);
    chk("rr_one_cyc", 32'(round_rst), 32'd0);
    // start pulses ignored in READY
    cyc("rdy_st", 0, 1, 0, 16'h0);
    cyc("rdy_st", 1, 0, 0, 16'h0);
    cyc("rdy_st", 0, 1, 0, 16'h0);
    chk("play_state", 32'(state), 32'd2);
    chk("play_frz", 32'(freeze), 32'd0);

    // high score and priority death+tick
    cyc("play", 0, 0, 0, 16'h0042);
    cyc("play", 1, 0, 0, 16'h0042);
    cyc("die_tick", 0, 1, 1, 16'h0000);
    chk("die_state", 32'(state), 32'd3);
    chk("die_lives", 32'(lives), 32'd2);
    chk("die_hs", 32'(high_score_bcd), 32'h42);
    // start ignored in DYING; counter restarted at 0
    cyc("dy_st", 0, 0, 0, 16'h0);
    cyc("dy_st", 1, 0, 0, 16'h0);
    ticks("dy", 3, 16'h0);
    chk("dy_back_rdy", 32'(state), 32'd1);

    ticks("r2", 2, 16'h0);
    cyc("p37", 0, 0, 0, 16'h0037);
    chk("hs_keep", 32'(high_score_bcd), 32'h42);
    cyc("p105", 0, 0, 0, 16'h0105);
    chk("hs_new", 32'(high_score_bcd), 32'h105);
    cyc("d2", 0, 0, 1, 16'h0);
    ticks("dy2", 3, 16'h0);
    ticks("r3", 2, 16'h0);
    cyc("d3", 0, 0, 1, 16'h0);
    ticks("dy3", 3, 16'h0);
    chk("go_state", 32'(state), 32'd4);
    chk("go_flag", 32'(game_over), 32'd1);
    chk("go_lives", 32'(lives), 32'd0);
    cyc("go_dead", 0, 1, 1, 16'h9999);
    cyc("restart", 1, 0, 0, 16'h0);
    chk("rs_lives", 32'(lives), 32'd3);
    chk("rs_hs", 32'(high_score_bcd), 32'h105);

    // reset mid-DYING with counter at 2
    cyc("rs0", 0, 0, 0, 16'h0);
    ticks("r4", 2, 16'h0);
    cyc("d4", 0, 0, 1, 16'h0);
    ticks("dy4", 2, 16'h0);
    start_btn = 1'b1;
    #2 rst = 1'b1;
    #1;
    m_reset();
    cmp_all("mid_rst");
    chk("mid_rst_st", 32'(state), 32'd0);
    chk("mid_rst_hs", 32'(high_score_bcd), 32'd0);
    cyc("held", 1, 0, 0, 16'h0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) cyc("held", 1, 0, 0, 16'h0);
    chk("held_idle", 32'(state), 32'd0);
    cyc("lo", 0, 0, 0, 16'h0);
    cyc("hi", 1, 0, 0, 16'h0);
    chk("lohi_ready", 32'(state), 32'd1);

    // randomized run
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 599) == 0) rst = 1'b1;
      else rst = 1'b0;
      cyc("rnd",
          ($urandom_range(0, 5) == 0),
          ($urandom_range(0, 2) == 0),
          ($urandom_range(0, 9) == 0),
          16'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/game_state_controller.md
GAME_STATE_CONTROLLER -- requirements
Module: game_state_controller

Interface
REQ-001 Parameter START_LIVES, default 3, lives loaded at game start (range 1-3).
REQ-002 Parameter READY_TICKS, default 120, tick count spent in READY before play.
REQ-003 Parameter DEATH_HOLD_TICKS, default 60, tick count spent in DYING.
REQ-004 clk  in  1  system clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 tick  in  1  frame strobe, one clk cycle wide.
REQ-007 start_btn  in  1  start request, level, already synchronous to clk.
REQ-008 pacman_is_dead  in  1  level death indication from game logic.
REQ-009 score_bcd  in  16  current score, 4 BCD digits.
REQ-010 state  out  3  IDLE=0, READY=1, PLAY=2, DYING=3, GAME_OVER=4.
REQ-011 freeze  out  1  high in every state except PLAY; game logic holds sprites while high.
REQ-012 round_rst  out  1  one-cycle pulse; resets sprite positions in game logic.
REQ-013 lives  out  2  remaining lives.
REQ-014 high_score_bcd  out  16  best score since reset.
REQ-015 game_over  out  1  high exactly while state is GAME_OVER.

Function
REQ-016 start_btn edge detection uses a registered previous value; start event = start_btn high and previous value low.
REQ-017 IDLE: a start event sets lives to START_LIVES, clears tick counter, pulses round_rst for one cycle and moves to READY on the same edge.
REQ-018 READY: the tick counter increments on each tick; on the tick that makes count equal READY_TICKS, state moves to PLAY and the counter clears.
REQ-019 PLAY: pacman_is_dead high on a clock edge moves to DYING, decrements lives by 1 and clears the counter; death takes priority over a same-cycle tick.
REQ-020 DYING: the counter increments on each tick; on the tick reaching DEATH_HOLD_TICKS, lives==0 moves to GAME_OVER, otherwise it moves to READY with a one-cycle round_rst pulse.
REQ-021 GAME_OVER: a start event behaves as in IDLE (lives reload, round_rst pulse, READY); high_score_bcd is retained.
REQ-022 start events in READY, PLAY and DYING are ignored.
REQ-023 pacman_is_dead is ignored outside PLAY.
REQ-024 lives never wraps; a decrement at 0 is impossible by construction and holds 0 if it occurs.
REQ-025 In PLAY, each cycle where score_bcd > high_score_bcd (16-bit unsigned compare, valid for BCD) loads high_score_bcd with score_bcd; no update in other states.
REQ-026 The tick counter is 8 bits wide and saturates at 255; READY_TICKS and DEATH_HOLD_TICKS are each between 1 and 255.
REQ-027 round_rst never stays high more than one cycle; back-to-back pulses are impossible because READY lasts at least one tick.
REQ-028 All outputs are registered.

Reset
REQ-029 On rst high, immediately and regardless of clk: state=IDLE, lives=0, counter=0, round_rst=0, high_score_bcd=0, and freeze=1.
REQ-030 On rst high, the start_btn previous-value register is forced to 1, so a button held through reset does not start a game.
REQ-031 An rst asserted mid-game, in any state, returns the block to IDLE and discards high_score_bcd.
REQ-032 Release of rst produces no round_rst pulse.

Verification
REQ-033 Parameters START_LIVES=3, READY_TICKS=2, DEATH_HOLD_TICKS=3; reset then start_btn 0->1 -> round_rst pulse 1 cycle, state=1, lives=3; after 2 ticks -> state=2, freeze=0.
REQ-034 Death cycle: in PLAY assert pacman_is_dead one cycle -> state=3, lives=2, freeze=1; after 3 ticks -> round_rst pulse, state=1.
REQ-035 Game over: three deaths from lives=3 -> after third DYING hold, state=4, game_over=1, lives=0; then start event -> lives=3, state=1, high score kept.
REQ-036 High score: in PLAY drive score_bcd 0x0042, then death (score input drops to 0x0000) -> high_score_bcd=0x0042; later PLAY with 0x0037 -> stays 0x0042; with 0x0105 -> 0x0105.
REQ-037 Priority/ignore: in PLAY, pacman_is_dead and tick in the same cycle -> DYING with counter=0; start_btn pulses in READY/PLAY/DYING -> no state change, no round_rst.
REQ-038 Reset mid-DYING with counter=2 -> immediate state=0, lives=0, high_score_bcd=0; start_btn held high through reset release -> stays IDLE until a low-then-high transition.
